inst_encoder: RTL and testbench

Encodes decoded micro-op fields (register numbers, immediate, ALU control code, unsigned flag) back into 32-bit RV32I instruction words, the exact inverse of the `control` decoder's field mapping. It assigns each word a sequential instruction address and buffers it in a small FIFO behind a valid/ready handshake. It sits between the test-program generator and instruction memory or the fetch path, so that every word it emits decodes in `control` to the same fields it was given.

---
 rtl/inst_encoder.sv | 90 +++++++++
 tb/tb_inst_encoder.sv | 150 +++++++++++++++
 2 files changed

// File: rtl/inst_encoder.sv
// inst_encoder: encodes ALU micro-ops into RV32I words and queues each with its address in a FIFO.
// Define INST_ENC_RANGE_CHECK_EN to reject immediates that do not fit the encoded field.
module inst_encoder #(
  parameter int          DEPTH     = 4,
  parameter logic [31:0] BASE_ADDR = 32'h0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        restart,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [3:0]  alu_control,
  input  logic        is_unsigned,
  input  logic        use_imm,
  input  logic [4:0]  rs1_num,
  input  logic [4:0]  rs2_num,
  input  logic [4:0]  rd_num,
  input  logic [31:0] imm_small,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] inst,
  output logic [31:0] inst_addr,
  output logic        err
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  logic [31:0]   mem_inst [DEPTH];
  logic [31:0]   mem_addr [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count;
  logic [31:0]   next_addr, word;
  logic [2:0]    f3;
  logic          is_add, is_sub, is_sll, is_slt, is_xor, known, range_bad, illegal;
  logic          accept, push, pop;
  assign is_add = alu_control == 4'b0010;
  assign is_sub = alu_control == 4'b0100;
  assign is_sll = alu_control == 4'b0001;
  assign is_slt = alu_control == 4'b0101;
  assign is_xor = alu_control == 4'b0110;
  assign known  = is_add | is_sub | is_sll | is_slt | is_xor;
  assign f3 = is_sll ? 3'd1 : is_slt ? {2'b01, is_unsigned} : is_xor ? 3'd4 : 3'd0;
`ifdef INST_ENC_RANGE_CHECK_EN
  assign range_bad = use_imm && (is_sll ? |imm_small[31:5]
                                        : !(&imm_small[31:11] || !(|imm_small[31:11])));
`else
  logic unused_imm;
  assign unused_imm = ^imm_small[31:12];
  assign range_bad  = 1'b0;
`endif
  assign illegal = !known || ((is_sub || is_xor) && use_imm) || (is_unsigned && !is_slt) || range_bad;
  assign word = !use_imm ? {is_sub ? 7'h20 : 7'h00, rs2_num, rs1_num, f3, rd_num, 7'h33}
              : is_sll   ? {7'h00, imm_small[4:0], rs1_num, f3, rd_num, 7'h13}
              :            {imm_small[11:0], rs1_num, f3, rd_num, 7'h13};
  assign in_ready  = count != CW'(DEPTH);
  assign out_valid = count != '0;
  assign accept    = in_valid && in_ready;
  assign push      = accept && !illegal && !restart;
  assign pop       = out_valid && out_ready && !restart;
  assign inst      = mem_inst[rd_ptr];
  assign inst_addr = mem_addr[rd_ptr];
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_inst[i] <= '0;
        mem_addr[i] <= '0;
      end
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      next_addr <= BASE_ADDR;
      err       <= 1'b0;
    end else if (restart) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      next_addr <= BASE_ADDR;
      err       <= 1'b0;
    end else begin
      err <= accept && illegal;
      if (push) begin
        mem_inst[wr_ptr] <= word;
        mem_addr[wr_ptr] <= next_addr;
        wr_ptr           <= wr_ptr + 1'b1;
        next_addr        <= next_addr + 32'd4;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      if (push != pop) count <= push ? count + 1'b1 : count - 1'b1;
    end
  end
endmodule

// File: tb/tb_inst_encoder.sv
// tb_inst_encoder: directed micro-ops with hand-computed words; a scoreboard queue is checked by a separate monitor.
`timescale 1ns/1ps
module tb_inst_encoder;
  logic        clk = 0, rst_n = 0, restart = 0, in_valid = 0, is_unsigned = 0, use_imm = 0, out_ready = 0;
  logic [3:0]  alu_control = '0;
  logic [4:0]  rs1_num = '0, rs2_num = '0, rd_num = '0;
  logic [31:0] imm_small = '0;
  logic        in_ready, out_valid, err;
  logic [31:0] inst, inst_addr;
  int          vectors = 0, miscompares = 0;
  logic [63:0] sb [$];
  logic [31:0] exp_addr = 32'h0;
  localparam logic [3:0] ADD = 4'b0010, SUB = 4'b0100, SLL = 4'b0001, SLT = 4'b0101, XOR = 4'b0110;
`ifdef INST_ENC_RANGE_CHECK_EN
  localparam bit RC = 1'b1;
`else
  localparam bit RC = 1'b0;
`endif
  localparam logic [31:0] ADDI_W [5] = '{32'h00100093, 32'h00200113, 32'h00300193, 32'h00400213, 32'h00500293};

  always #5 clk = ~clk;

  inst_encoder #(.DEPTH(4), .BASE_ADDR(32'h0)) dut (
    .clk(clk), .rst_n(rst_n), .restart(restart), .in_valid(in_valid), .in_ready(in_ready),
    .alu_control(alu_control), .is_unsigned(is_unsigned), .use_imm(use_imm),
    .rs1_num(rs1_num), .rs2_num(rs2_num), .rd_num(rd_num), .imm_small(imm_small),
    .out_valid(out_valid), .out_ready(out_ready), .inst(inst), .inst_addr(inst_addr), .err(err)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: inputs settle at the falling edge; the head is taken at the next rising edge.
  always @(negedge clk) begin
    #2;
    if (rst_n && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL unexpected_word: got %h @ %h expected no output", inst, inst_addr);
      end else check("out_word_addr", {inst, inst_addr}, sb.pop_front());
    end
  end

  task automatic send(input logic [3:0] code, input logic uns, input logic imm_sel,
                      input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                      input logic [31:0] imm, input logic [31:0] exp_word, input bit legal);
    int n = 0;
    alu_control = code; is_unsigned = uns; use_imm = imm_sel;
    rs1_num = rs1; rs2_num = rs2; rd_num = rd; imm_small = imm; in_valid = 1'b1;
    while (!in_ready && n < 50) begin @(negedge clk); n++; end
    check("in_ready_wait", in_ready, 1);
    if (legal) begin
      sb.push_back({exp_word, exp_addr});
      exp_addr += 32'd4;
    end
    @(negedge clk);
    in_valid = 1'b0;
    if (legal) check("latency_out_valid", out_valid, 1);
    else begin
      check("err_pulse", err, 1);
      @(negedge clk);
      check("err_one_cycle", err, 0);
    end
  endtask

  task automatic drain();
    int n = 0;
    out_ready = 1'b1;
    while (sb.size() != 0 && n < 50) begin @(negedge clk); n++; end
    check("drain_queue_empty", sb.size(), 0);
    check("drain_out_valid", out_valid, 0);
  endtask

  initial begin
    #12;
    check("rst_out_valid", out_valid, 0);
    check("rst_in_ready", in_ready, 1);
    check("rst_err", err, 0);
    check("rst_inst", {inst, inst_addr}, 64'h0);
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk); out_ready = 1'b1;
    // Illegal micro-ops first: the first legal word must still get address 0.
    send(SUB, 0, 1, 2, 3, 1, 32'h0, 32'h0, 0);
    send(ADD, 1, 0, 1, 2, 3, 32'h0, 32'h0, 0);
    send(4'b0011, 0, 0, 1, 2, 3, 32'h0, 32'h0, 0);
    send(XOR, 0, 1, 1, 2, 3, 32'h0, 32'h0, 0);
    send(ADD, 0, 0, 1, 2, 3, 32'h0, 32'h002081B3, 1);
    send(ADD, 0, 1, 0, 0, 5, 32'hFFFFFFFF, 32'hFFF00293, 1);
    send(SUB, 0, 0, 2, 3, 1, 32'h0, 32'h403100B3, 1);
    send(SLL, 0, 0, 4, 5, 6, 32'h0, 32'h00521333, 1);
    send(SLT, 0, 0, 8, 9, 7, 32'h0, 32'h009423B3, 1);
    send(SLT, 1, 0, 8, 9, 7, 32'h0, 32'h009433B3, 1);
    send(XOR, 0, 0, 11, 12, 10, 32'h0, 32'h00C5C533, 1);
    send(SLL, 0, 1, 2, 31, 1, 32'd5, 32'h00511093, 1);
    send(SLT, 0, 1, 4, 0, 3, 32'hFFFFFFFB, 32'hFFB22193, 1);
    send(SLT, 1, 1, 4, 0, 3, 32'd100, 32'h06423193, 1);
    send(ADD, 0, 1, 0, 0, 0, 32'd2048, 32'h80000013, !RC);
    drain();
    // Full FIFO: restart to realign addresses, then fill with the consumer stalled.
    out_ready = 1'b0; restart = 1'b1;
    @(negedge clk); restart = 1'b0; sb.delete(); exp_addr = 32'h0;
    for (int i = 0; i < 4; i++) send(ADD, 0, 1, 0, 0, 5'(i + 1), 32'(i + 1), ADDI_W[i], 1);
    check("full_in_ready", in_ready, 0);
    check("stall_head", {inst, inst_addr}, {ADDI_W[0], 32'h0});
    @(negedge clk);
    check("stall_hold", {inst, inst_addr}, {ADDI_W[0], 32'h0});
    check("full_in_ready_hold", in_ready, 0);
    out_ready = 1'b1;
    check("no_bypass_in_ready", in_ready, 0);
    send(ADD, 0, 1, 0, 0, 5, 32'd5, ADDI_W[4], 1);
    drain();
    // Restart with three queued words and a push presented in the same cycle.
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) send(ADD, 0, 1, 0, 0, 5'(i + 1), 32'(i + 1), ADDI_W[i], 1);
    alu_control = ADD; use_imm = 1'b0; is_unsigned = 1'b0; in_valid = 1'b1; restart = 1'b1;
    sb.delete(); exp_addr = 32'h0;
    @(negedge clk); restart = 1'b0; in_valid = 1'b0;
    check("restart_out_valid", out_valid, 0);
    check("restart_in_ready", in_ready, 1);
    check("restart_err", err, 0);
    out_ready = 1'b1;
    send(ADD, 0, 0, 1, 2, 3, 32'h0, 32'h002081B3, 1);
    drain();
    // Asynchronous reset mid-stream, while err is high.
    out_ready = 1'b0;
    send(ADD, 0, 1, 0, 0, 1, 32'd1, ADDI_W[0], 1);
    send(ADD, 0, 1, 0, 0, 2, 32'd2, ADDI_W[1], 1);
    alu_control = SUB; use_imm = 1'b1; is_unsigned = 1'b0; in_valid = 1'b1;
    @(negedge clk); in_valid = 1'b0;
    check("err_before_reset", err, 1);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_out_valid", out_valid, 0);
    check("async_rst_err", err, 0);
    check("async_rst_in_ready", in_ready, 1);
    sb.delete(); exp_addr = 32'h0;
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk); out_ready = 1'b1;
    send(SUB, 0, 0, 2, 3, 1, 32'h0, 32'h403100B3, 1);
    drain();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
